minc_prog_loader: RTL and testbench
===================================

Name: minc_prog_loader

Overview:
- Serial program loader sitting directly upstream of the minc core.
- Receives a framed program image over a UART line and writes 10-bit instruction words into the core's 256-entry instruction memory.
- Holds the core in reset (cpu_nreset low) until a complete, checksum-valid image has been written.

Parameters:
- CLKS_PER_BIT, 434, CLK cycles per UART bit (8N1, LSB first); minimum 4.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- CLK  in  1  system clock.
- nRESET  in  1  reset, asynchronous, active-low; clock CLK.
- RXD  in  1  UART receive line, idle high, asynchronous to CLK.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  8  write address.
- mem_wdata  out  10  instruction word {opcode[1:0], operand[7:0]}.
- cpu_nreset  out  1  active-low reset to the minc core.
- busy  out  1  frame in progress (from SYNC accepted to checksum checked).
- done  out  1  last frame loaded successfully.
- err  out  1  last frame failed (framing, format or checksum).

Behaviour:
- Reset values (asynchronous, all outputs): mem_we=0, mem_addr=0, mem_wdata=0, cpu_nreset=0, busy=0, done=0, err=0. RX FSM goes to IDLE; frame FSM goes to F_SYNC.
- RXD passes through a 2-flop synchronizer before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge.
  - START: sample at CLKS_PER_BIT/2. If the line is high, the edge was a glitch: return to IDLE with no byte and no error.
  - DATA: 8 samples, each CLKS_PER_BIT apart, LSB first.
  - STOP: one sample. High -> byte_valid pulses one cycle with the byte. Low -> framing-error pulse and no byte_valid.
  - Returns to IDLE after the stop sample. The next start bit may begin immediately.
- Frame FSM states: F_SYNC, F_COUNT, F_HI, F_LO, F_SUM.
  - F_SYNC: bytes other than SYNC_BYTE are ignored. On SYNC_BYTE: busy=1, done=0, err=0, cpu_nreset=0, addr=0, sum=0; go to F_COUNT.
  - F_COUNT: byte N is the word count. N=0 means 256. Go to F_HI.
  - F_HI: byte bits[7:2] must be 0, else error. Store bits[1:0] and add the byte to sum.
  - F_LO: add the byte to sum. In the cycle after this byte_valid: mem_we=1 for exactly one cycle, mem_addr=addr, mem_wdata={hi[1:0], lo}. Then addr increments (8-bit wrap).
    - Words remaining -> F_HI.
    - Otherwise -> F_SUM.
  - F_SUM: byte compared with sum, the 8-bit modulo sum of all HI and LO bytes; SYNC and COUNT bytes are excluded.
    - Match: done=1, busy=0; cpu_nreset=1 from the next cycle.
    - Mismatch: err=1, busy=0, cpu_nreset stays 0.
    - Either way, go to F_SYNC.
- Errors inside a frame (framing error in any state except F_SYNC, or a bad HI byte): err=1, busy=0, cpu_nreset=0, go to F_SYNC.
  - Words already written are not rolled back.
  - A framing error while in F_SYNC is ignored.
- cpu_nreset is 1 only while done=1. Any new SYNC_BYTE re-asserts core reset in the cycle after its byte_valid.
- mem_addr/mem_wdata hold their last values when mem_we=0.
- At most one mem_we per two received bytes; no back-pressure exists.
- An nRESET assertion mid-frame aborts immediately: a partial image stays in memory and the core stays held.

Test Plan (CLKS_PER_BIT=8):
- Reset, RXD idle for 200 cycles -> all outputs 0, no mem_we.
- Send A5,02,01,05,02,FF,07 -> mem_we twice: (addr 0, 0x105) then (addr 1, 0x2FF); done=1, cpu_nreset=1, err=0.
- Same frame with checksum 08 -> both writes occur, err=1, done=0, cpu_nreset=0.
- Send 3C,A5,01,04,00,04 (HI byte has bits[7:2]≠0) -> 3C ignored; err=1 after 04, no mem_we, frame FSM back in F_SYNC.
- Start-bit glitch: RXD low for 2 cycles, then a valid frame -> no spurious byte, frame loads correctly.
- Load a valid frame, then send A5 -> cpu_nreset falls and done clears one cycle after the A5 stop sample.
- Pull nRESET low mid-word -> all outputs 0 immediately; the next full frame loads normally.
- N=00 with 256 words -> addresses 0..255, each written once, then done=1.

Source files
------------

// File: rtl/minc_prog_loader.sv
// minc_prog_loader: UART (8N1) program loader for the minc core.
// Parses frames of the form SYNC, COUNT, {HI, LO} x N, SUM and writes the
// 10-bit words into instruction memory. The core stays in reset until a
// checksum-valid image has been fully written.
module minc_prog_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        RXD,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [9:0]  mem_wdata,
    output logic        cpu_nreset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int              CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   FULL_C = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_C = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [2:0] {F_SYNC, F_COUNT, F_HI, F_LO, F_SUM} fr_state_t;

    // ---------------- receiver ----------------
    logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ferr_q, rx_ferr_d;

    // Two-flop synchronizer on RXD plus a delayed copy for falling-edge detection.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= RXD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // Receiver state registers.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            rx_state_q <= IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // Receiver next state: mid-bit sampling, glitch rejection on the start bit.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = START;
                    cnt_d      = '0;
                end else begin
                    rx_state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    if (!rxd_sync_q) begin
                        rx_state_d = DATA;
                    end else begin
                        rx_state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_C) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        rx_state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_C) begin
                    cnt_d      = '0;
                    rx_state_d = IDLE;
                    if (rxd_sync_q) begin
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                rx_state_d = IDLE;
                cnt_d      = '0;
            end
        endcase
    end

    // ---------------- frame parser ----------------
    fr_state_t   fr_state_q, fr_state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  sum_q, sum_d;
    logic [1:0]  hi_q, hi_d;
    logic [8:0]  left_q, left_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [9:0]  mem_wdata_q, mem_wdata_d;
    logic        cpu_nreset_q, cpu_nreset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Frame parser registers and registered outputs.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            fr_state_q   <= F_SYNC;
            addr_q       <= 8'h00;
            sum_q        <= 8'h00;
            hi_q         <= 2'b00;
            left_q       <= 9'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 8'h00;
            mem_wdata_q  <= 10'h000;
            cpu_nreset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            fr_state_q   <= fr_state_d;
            addr_q       <= addr_d;
            sum_q        <= sum_d;
            hi_q         <= hi_d;
            left_q       <= left_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_nreset_q <= cpu_nreset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Frame parser next state. The core leaves reset one cycle after done
    // rises, and is re-held in the same cycle a new SYNC clears done.
    always_comb begin
        fr_state_d   = fr_state_q;
        addr_d       = addr_q;
        sum_d        = sum_q;
        hi_d         = hi_q;
        left_d       = left_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_nreset_d = done_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        if (fr_state_q == F_SYNC) begin
            if (rx_valid_q && (shift_q == SYNC_BYTE)) begin
                busy_d       = 1'b1;
                done_d       = 1'b0;
                err_d        = 1'b0;
                cpu_nreset_d = 1'b0;
                addr_d       = 8'h00;
                sum_d        = 8'h00;
                fr_state_d   = F_COUNT;
            end else begin
                fr_state_d = F_SYNC;
            end
        end else if (rx_ferr_q) begin
            err_d        = 1'b1;
            busy_d       = 1'b0;
            cpu_nreset_d = 1'b0;
            fr_state_d   = F_SYNC;
        end else if (rx_valid_q) begin
            case (fr_state_q)
                F_COUNT: begin
                    left_d     = (shift_q == 8'h00) ? 9'd256 : {1'b0, shift_q};
                    fr_state_d = F_HI;
                end
                F_HI: begin
                    if (shift_q[7:2] != 6'd0) begin
                        err_d        = 1'b1;
                        busy_d       = 1'b0;
                        cpu_nreset_d = 1'b0;
                        fr_state_d   = F_SYNC;
                    end else begin
                        hi_d       = shift_q[1:0];
                        sum_d      = sum_q + shift_q;
                        fr_state_d = F_LO;
                    end
                end
                F_LO: begin
                    sum_d       = sum_q + shift_q;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = {hi_q, shift_q};
                    addr_d      = addr_q + 8'd1;
                    left_d      = left_q - 9'd1;
                    if (left_q == 9'd1) begin
                        fr_state_d = F_SUM;
                    end else begin
                        fr_state_d = F_HI;
                    end
                end
                F_SUM: begin
                    busy_d     = 1'b0;
                    fr_state_d = F_SYNC;
                    if (shift_q == sum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d        = 1'b1;
                        cpu_nreset_d = 1'b0;
                    end
                end
                default: begin
                    fr_state_d = F_SYNC;
                end
            endcase
        end else begin
            fr_state_d = fr_state_q;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_nreset = cpu_nreset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_minc_prog_loader.sv
// Directed bench for minc_prog_loader with a write scoreboard.
module tb_minc_prog_loader;

    localparam int CPB = 8;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        RXD = 1'b1;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [9:0]  mem_wdata;
    logic        cpu_nreset, busy, done, err;

    int n_vec = 0;
    int n_err = 0;

    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    logic [7:0]  frm_q[$];

    minc_prog_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .CLK(CLK), .nRESET(nRESET), .RXD(RXD),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_nreset(cpu_nreset), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    // Record every memory write on the falling edge.
    always @(negedge CLK) begin
        if (nRESET && mem_we) obs_q.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RXD = b;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_data(b);
        send_bit(1'b1);
    endtask

    task automatic send_frame();
        while (frm_q.size() > 0) send_byte(frm_q.pop_front());
        repeat (20) @(negedge CLK);
    endtask

    task automatic check_writes(input string tag);
        logic [17:0] e, o;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_word"}, o, e);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_status(input string tag, input logic b, input logic d,
                                input logic e, input logic c);
        chk({tag, "_status"}, {busy, done, err, cpu_nreset}, {b, d, e, c});
    endtask

    initial begin
        logic [7:0] sum;
        logic [1:0] hi;
        logic [7:0] lo;

        // 1: reset and idle line
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        repeat (200) @(negedge CLK);
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_bus", {mem_we, mem_addr, mem_wdata}, 19'd0);
        check_writes("reset");

        // 2: valid two-word frame
        frm_q = '{8'hA5, 8'h02, 8'h01, 8'h05, 8'h02, 8'hFF, 8'h07};
        exp_q.push_back({8'd0, 10'h105});
        exp_q.push_back({8'd1, 10'h2FF});
        send_frame();
        check_writes("ok2");
        check_status("ok2", 1'b0, 1'b1, 1'b0, 1'b1);

        // 3: bad checksum
        frm_q = '{8'hA5, 8'h02, 8'h01, 8'h05, 8'h02, 8'hFF, 8'h08};
        exp_q.push_back({8'd0, 10'h105});
        exp_q.push_back({8'd1, 10'h2FF});
        send_frame();
        check_writes("badsum");
        check_status("badsum", 1'b0, 1'b0, 1'b1, 1'b0);

        // 4: junk before SYNC, then malformed HI byte
        frm_q = '{8'h3C, 8'hA5, 8'h01, 8'h04, 8'h00, 8'h04};
        send_frame();
        check_writes("badhi");
        check_status("badhi", 1'b0, 1'b0, 1'b1, 1'b0);

        // 5: start-bit glitch followed by a valid frame
        RXD = 1'b0;
        repeat (2) @(negedge CLK);
        RXD = 1'b1;
        repeat (30) @(negedge CLK);
        check_writes("glitch_idle");
        check_status("glitch_idle", 1'b0, 1'b0, 1'b1, 1'b0);
        frm_q = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h12};
        exp_q.push_back({8'd0, 10'h012});
        send_frame();
        check_writes("glitch");
        check_status("glitch", 1'b0, 1'b1, 1'b0, 1'b1);

        // 6: new SYNC re-holds the core right after its stop sample
        send_data(8'hA5);
        check_status("resync_pre", 1'b0, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1);
        check_status("resync_post", 1'b1, 1'b0, 1'b0, 1'b0);

        // 7: reset asserted in the middle of a LO byte
        send_byte(8'h01);
        send_byte(8'h00);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        nRESET = 1'b0;
        #1;
        check_status("abort", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_bus", {mem_we, mem_addr, mem_wdata}, 19'd0);
        RXD = 1'b1;
        repeat (4) @(negedge CLK);
        nRESET = 1'b1;
        repeat (30) @(negedge CLK);
        check_writes("abort");
        frm_q = '{8'hA5, 8'h02, 8'h03, 8'hAA, 8'h00, 8'h55, 8'h02};
        exp_q.push_back({8'd0, 10'h3AA});
        exp_q.push_back({8'd1, 10'h055});
        send_frame();
        check_writes("after_abort");
        check_status("after_abort", 1'b0, 1'b1, 1'b0, 1'b1);

        // 8: N=0 means 256 words
        sum = 8'h00;
        frm_q.push_back(8'hA5);
        frm_q.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            hi = 2'(i);
            lo = 8'(i) ^ 8'h5A;
            frm_q.push_back({6'd0, hi});
            frm_q.push_back(lo);
            sum = sum + {6'd0, hi} + lo;
            exp_q.push_back({8'(i), hi, lo});
        end
        frm_q.push_back(sum);
        send_frame();
        check_writes("full256");
        check_status("full256", 1'b0, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
